// File: rtl/grf_pkg.sv
// Shared CPU package for the general register file: default widths,
// the hard-wired zero register index and the register address type.
package grf_pkg;

  localparam int unsigned GRF_DATA_W = 32;
  localparam int unsigned GRF_ADDR_W = 5;

  // Register index that always reads as zero and ignores writes.
  localparam logic [GRF_ADDR_W-1:0] GRF_REG_ZERO = 5'd0;

  typedef logic [GRF_ADDR_W-1:0] reg_addr_t;

  // True when an address names a real (non-zero) register.
  function automatic logic grf_addr_live(input reg_addr_t addr);
    return (addr != GRF_REG_ZERO);
  endfunction

endpackage : grf_pkg

// File: rtl/grf_scoreboard.sv
// Pending-bit tracker for the register file. One bit per register marks an
// issued instruction whose result has not yet been written back. An issue
// and a write-back to the same register in the same cycle leave the bit set,
// because the younger writer is still outstanding. Bit 0 is never set.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W = GRF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_iss_live;
  logic            w_wr_live;

  // Qualify issue and write-back strobes; register 0 takes part in neither.
  always_comb begin
    w_iss_live = iss_en && (iss_addr != ADDR_W'(GRF_REG_ZERO));
    w_wr_live  = we && (wa != ADDR_W'(GRF_REG_ZERO));
  end

  // Next pending state: set wins over clear, untouched bits hold.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < int'(NREG); i++) begin
      if (w_iss_live && (iss_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (w_wr_live && (wa == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Pending-bit state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule : grf_scoreboard

// File: rtl/grf.sv
// General register file: 2**ADDR_W registers, two combinational read ports,
// one write port, and a pending-bit scoreboard that raises stall when a read
// port names a register still awaiting its result.
// Optional feature macro: GRF_BYPASS_EN -- forwards same-cycle write data to
// matching read ports and treats the written register as no longer pending
// for the stall decision. Stored state is identical with or without it.
module grf
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W = GRF_DATA_W,
  parameter int unsigned ADDR_W = GRF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      ra1,
  output logic [DATA_W-1:0]      rd1,
  input  logic [ADDR_W-1:0]      ra2,
  output logic [DATA_W-1:0]      rd2,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic [DATA_W-1:0]      wd,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   stall,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);

  localparam int unsigned NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(GRF_REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   w_busy;
  logic              w_wr_live;
  logic [DATA_W-1:0] w_st1;
  logic [DATA_W-1:0] w_st2;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_pend1;
  logic              w_pend2;

  grf_scoreboard #(
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .we       (we),
    .wa       (wa),
    .busy_vec (w_busy)
  );

  // A write only lands when it targets a real register.
  always_comb begin
    w_wr_live = we && (wa != ZERO_IDX);
  end

  // Register storage; reset clears every entry and blocks the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_live) begin
      r_regs[wa] <= wd;
    end else begin
      r_regs[wa] <= r_regs[wa];
    end
  end

  // Stored-content read mux; register 0 is forced to zero.
  always_comb begin
    if (ra1 == ZERO_IDX) begin
      w_st1 = '0;
    end else begin
      w_st1 = r_regs[ra1];
    end
    if (ra2 == ZERO_IDX) begin
      w_st2 = '0;
    end else begin
      w_st2 = r_regs[ra2];
    end
  end

`ifdef GRF_BYPASS_EN
  // Same-cycle write-to-read match for each read port.
  always_comb begin
    w_byp1 = w_wr_live && (wa == ra1);
    w_byp2 = w_wr_live && (wa == ra2);
  end
`else
  // Without forwarding, reads never see in-flight write data.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
  end
`endif

  // Read data: forwarded write data when matched, stored contents otherwise.
  always_comb begin
    if (w_byp1) begin
      rd1 = wd;
    end else begin
      rd1 = w_st1;
    end
    if (w_byp2) begin
      rd2 = wd;
    end else begin
      rd2 = w_st2;
    end
  end

  // Hazard detection: a read of a pending, non-forwarded register stalls.
  always_comb begin
    w_pend1 = (ra1 != ZERO_IDX) && w_busy[ra1] && !w_byp1;
    w_pend2 = (ra2 != ZERO_IDX) && w_busy[ra2] && !w_byp2;
    stall   = w_pend1 || w_pend2;
  end

  assign busy_vec = w_busy;

endmodule : grf

// File: tb/tb_grf.sv
// Directed self-checking bench for grf (default parameters).
module tb_grf;

  logic        clk;
  logic        reset;
  logic [4:0]  ra1;
  logic [31:0] rd1;
  logic [4:0]  ra2;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        stall;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_err    = 0;

  grf dut (
    .clk      (clk),
    .reset    (reset),
    .ra1      (ra1),
    .rd1      (rd1),
    .ra2      (ra2),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .stall    (stall),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ra1 = 5'd0; ra2 = 5'd0; we = 1'b0; wa = 5'd0; wd = 32'd0;
    iss_en = 1'b0; iss_addr = 5'd0;
    tick();
    reset = 1'b0;

    // Reset state
    ra1 = 5'd5; ra2 = 5'd31; #1;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);

    // Write / read
    we = 1'b1; wa = 5'd8; wd = 32'h12345678;
    tick();
    we = 1'b0; ra1 = 5'd8; #1;
    chk("wr8_rd1", rd1, 32'h12345678);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    tick();
    we = 1'b0; ra2 = 5'd0; ra1 = 5'd0; #1;
    chk("wr0_rd2", rd2, 32'd0);
    chk("wr0_rd1", rd1, 32'd0);
    we = 1'b1; wa = 5'd31; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra2 = 5'd31; #1;
    chk("wr31_rd2", rd2, 32'hDEADBEEF);

    // Scoreboard set / stall / clear
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_en = 1'b0; ra1 = 5'd9; ra2 = 5'd0; #1;
    chk("sb9_stall", {31'd0, stall}, 32'd1);
    chk("sb9_busy", busy_vec, 32'h0000_0200);
    we = 1'b1; wa = 5'd9; wd = 32'h0000_0099; #1;
`ifdef GRF_BYPASS_EN
    chk("sb9_wb_stall", {31'd0, stall}, 32'd0);
`else
    chk("sb9_wb_stall", {31'd0, stall}, 32'd1);
`endif
    tick();
    we = 1'b0; #1;
    chk("sb9_clr_stall", {31'd0, stall}, 32'd0);
    chk("sb9_clr_busy", busy_vec, 32'd0);
    chk("sb9_rd1", rd1, 32'h0000_0099);

    // Issue to register 0 is ignored
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    iss_en = 1'b0; #1;
    chk("iss0_busy", busy_vec, 32'd0);

    // Write to a non-pending register leaves pending bits alone
    iss_en = 1'b1; iss_addr = 5'd2;
    tick();
    iss_en = 1'b0; we = 1'b1; wa = 5'd8; wd = 32'h0000_0055;
    tick();
    we = 1'b0; ra1 = 5'd8; #1;
    chk("np_busy", busy_vec, 32'h0000_0004);
    chk("np_rd1", rd1, 32'h0000_0055);

    // Simultaneous set and clear on pending register 4
    iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    iss_en = 1'b1; iss_addr = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h0000_4444;
    tick();
    iss_en = 1'b0; we = 1'b0; ra1 = 5'd4; ra2 = 5'd0; #1;
    chk("sim_busy", busy_vec, 32'h0000_0014);
    chk("sim_rd1", rd1, 32'h0000_4444);
    chk("sim_stall", {31'd0, stall}, 32'd1);
    we = 1'b1; wa = 5'd2; wd = 32'h0000_0002;
    tick();
    wa = 5'd4; wd = 32'h0000_0444;
    tick();
    we = 1'b0; #1;
    chk("sim_clr_busy", busy_vec, 32'd0);
    chk("sim_clr_rd1", rd1, 32'h0000_0444);

    // Bypass behaviour on pending register 7
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
    tick();
    we = 1'b0; iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    iss_en = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd0; #1;
`ifdef GRF_BYPASS_EN
    chk("byp_rd1", rd1, 32'hA5A5A5A5);
    chk("byp_stall", {31'd0, stall}, 32'd0);
`else
    chk("byp_rd1", rd1, 32'h0000_0077);
    chk("byp_stall", {31'd0, stall}, 32'd1);
`endif
    tick();
    we = 1'b0; #1;
    chk("byp_after_rd1", rd1, 32'hA5A5A5A5);
    chk("byp_after_stall", {31'd0, stall}, 32'd0);

    // Stall through read port 2
    iss_en = 1'b1; iss_addr = 5'd13;
    tick();
    iss_en = 1'b0; ra1 = 5'd0; ra2 = 5'd13; #1;
    chk("ra2_stall", {31'd0, stall}, 32'd1);

    // Mid-operation reset with pending bits 3, 12, 13
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd12;
    tick();
    iss_en = 1'b0; #1;
    chk("pre_rst_busy", busy_vec, 32'h0000_3008);
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h0000_0333; iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    reset = 1'b0; we = 1'b0; iss_en = 1'b0; ra1 = 5'd3; ra2 = 5'd8; #1;
    chk("mid_rst_busy", busy_vec, 32'd0);
    chk("mid_rst_rd1", rd1, 32'd0);
    chk("mid_rst_rd2", rd2, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_grf
